// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data RAM responder with fixed access latency.
// Optional DMEM_STATS_EN adds rd_count/wr_count completion counters.
module dmem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              stall,
   output logic              req_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t              state;
   logic [3:0]          cnt;
   logic                op_wr;
   logic [ADDR_W-1:0]   idx;
   logic [DATA_W-1:0]   wq;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic req, vreq, commit;
   logic unused_addr;

   assign req         = memread | memwrite;
   assign vreq        = (memread ^ memwrite) && (addr[1:0] == 2'b00);
   assign commit      = (state == BUSY) && (cnt == 4'd0);
   assign unused_addr = ^addr[31:ADDR_W+2];

   // stall forced low during reset so the pipeline is never frozen by it
   assign stall = !rst && (((state == IDLE) && vreq) || (state == BUSY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         op_wr       <= 1'b0;
         idx         <= '0;
         wq          <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         req_err     <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         req_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (vreq) begin
                  op_wr <= memwrite;
                  idx   <= addr[ADDR_W+1:2];
                  wq    <= wdata;
                  cnt   <= CNT_INIT;
                  state <= BUSY;
               end else if (req) begin
                  req_err <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!op_wr) begin
                     rdata       <= mem[idx];
                     rdata_valid <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM is never cleared; reset aborts a store by leaving BUSY
   always_ff @(posedge clk) begin
      if (commit && op_wr)
         mem[idx] <= wq;
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (commit) begin
         if (op_wr)
            wr_count <= wr_count + 16'd1;
         else
            rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the MEM stage of the 5-stage pipeline. Accepts the memread/memwrite strobes that the main decoder generates and that EX/MEM carries, along with the ALU byte address and store data. Services each access against an internal word-addressed RAM with a fixed multi-cycle latency. Holds the pipeline through `stall` until the access completes.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; the RAM holds 2**ADDR_W words.
- `DATA_W`, default 32: word width.
- `LAT`, default 2: number of BUSY cycles per access. Legal range is 1..15.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `memread`, input, 1: load request from EX/MEM.
- `memwrite`, input, 1: store request from EX/MEM.
- `addr`, input, 32: byte address from the ALU result.
- `wdata`, input, DATA_W: store data.
- `rdata`, output, DATA_W: registered load data.
- `rdata_valid`, output, 1: one-cycle pulse when `rdata` is updated.
- `stall`, output, 1: freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `req_err`, output, 1: one-cycle pulse for a rejected request.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - BUSY: counts down the latency.
  - DONE: one cycle, releases the pipeline.
- A request is `memread | memwrite` sampled in IDLE.
- Valid request: exactly one strobe is set and `addr[1:0]==2'b00`.
  - On a valid request: latch the operation type, the word index `addr[ADDR_W+1:2]` and `wdata`. Load the counter with LAT-1. Go to BUSY.
  - Address bits above ADDR_W+1 are ignored, so addresses alias modulo 2**ADDR_W words.
- Invalid request: both strobes set, or a misaligned address.
  - No RAM access, no stall, stay in IDLE.
  - `req_err` pulses in the following cycle.
- BUSY:
  - Counter nonzero: decrement it.
  - Counter zero: perform the access on that edge and go to DONE.
    - A store writes the latched data to the latched index.
    - A load captures RAM[index] into `rdata`.
- DONE:
  - `rdata_valid` is 1 for a completed load and 0 for a completed store.
  - Strobes are ignored, because EX/MEM still holds the request just completed.
  - Next state is IDLE.
- `stall` is combinational: `(IDLE && valid request) || BUSY`. It is 0 in DONE, so the pipeline advances at the end of DONE.
- `rdata` holds its value until the next load completes. A store does not change it.
- Reset, including in the middle of an access:
  - State goes to IDLE and the counter clears.
  - `rdata`=0, `rdata_valid`=0, `req_err`=0, `stall`=0.
  - A pending store is discarded and never written.
  - RAM contents are not cleared.

## Timing
- Valid request first seen in cycle 0:
  - `stall` is high in cycles 0..LAT, which is LAT+1 cycles.
  - DONE is cycle LAT+1.
  - For a load, `rdata`/`rdata_valid` are valid in cycle LAT+1.
- Minimum spacing between accepted requests is LAT+2 cycles.
- `req_err` rises one cycle after the offending request is sampled in IDLE.
- Reads of a just-stored address return the new data. The store commits before DONE, so a back-to-back load sees it.

## Configuration
- `DMEM_STATS_EN`:
  - Defined:
    - Adds outputs `rd_count[15:0]` and `wr_count[15:0]`.
    - Each increments by 1 on the BUSY-to-DONE edge of a completed load or store respectively.
    - Both wrap from 16'hFFFF to 0.
    - Both reset to 0 on `rst`.
  - Undefined: the ports and counters do not exist, and all other behaviour is identical.

## Test plan
- LAT=2, store 32'hDEADBEEF at addr 0x10, then load from addr 0x10 -> each access shows `stall` for 3 cycles; the load gives `rdata`=32'hDEADBEEF with `rdata_valid`=1 in cycle 3 after the load request.
- Load from addr 0x13 -> `req_err` pulses once, `stall` stays 0, `rdata` unchanged.
- memread=memwrite=1 at addr 0x20 -> `req_err` pulses, and RAM[8] is unchanged (check with a later load).
- ADDR_W=8, store 32'h12345678 at addr 0x400, then load from addr 0x0 -> `rdata`=32'h12345678 (alias wrap).
- Store 32'hA5A5A5A5 to addr 0x40, with `rst` asserted in the second BUSY cycle -> all outputs 0 immediately; a later load of 0x40 returns the old value, not A5A5A5A5.
- With `DMEM_STATS_EN`: 3 loads and 2 stores -> `rd_count`=3, `wr_count`=2; after reset both are 0.
